// File: rtl/jt51_wrseq_pkg.sv
// Shared types and constants for the JT51 host-side write sequencer.
package jt51_wrseq_pkg;

  localparam int unsigned TMO_DEFAULT = 255;
  localparam int unsigned TMO_W       = 8;
  localparam int unsigned BYTE_W      = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    WAIT_A = 3'd2,
    DATA   = 3'd3,
    WAIT_D = 3'd4
  } state_t;

  typedef struct packed {
    logic [BYTE_W-1:0] addr;
    logic [BYTE_W-1:0] data;
  } pair_t;

  // States in which the busy timeout counter is armed
  function automatic logic is_timed(input state_t s);
    return s != IDLE;
  endfunction

endpackage

// File: rtl/jt51_wrseq_fifo.sv
// Register-based first-word-fall-through FIFO of (addr, data) pairs.
module jt51_wrseq_fifo
  import jt51_wrseq_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        push,
  input  logic        pop,
  input  pair_t       din,
  output pair_t       head,
  output logic        full,
  output logic        empty,
  output logic [AW:0] level
);

  pair_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = level == (AW+1)'(DEPTH);
  assign empty   = level == '0;
  assign head    = mem[rd_ptr];
  // A pop on the same edge frees a slot, so a push into a full FIFO is legal then
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/jt51_wrseq.sv
// Buffers (addr, data) pairs and replays them on the JT51 bus as an
// address write followed by a data write, pacing itself on the busy flag.
module jt51_wrseq
  import jt51_wrseq_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AW        = 3,
  parameter int unsigned SKIP_ADDR = 1,
  parameter int unsigned TMO       = TMO_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cen,
  input  logic              req_valid,
  input  logic [BYTE_W-1:0] req_addr,
  input  logic [BYTE_W-1:0] req_data,
  output logic              req_ready,
  input  logic              flush,
  output logic              write,
  output logic              a0,
  output logic [BYTE_W-1:0] dout,
  input  logic              busy,
  output logic [AW:0]       level,
  output logic              idle,
  output logic              err,
  input  logic              err_clr
);

  state_t             state_q, state_nx;
  pair_t              work_q, work_nx;
  pair_t              head;
  pair_t              req_pair;
  logic [BYTE_W-1:0]  last_addr_q, last_addr_nx;
  logic               last_vld_q, last_vld_nx;
  logic [TMO_W-1:0]   tmo_q, tmo_nx;
  logic               write_nx, a0_nx, err_nx;
  logic [BYTE_W-1:0]  dout_nx;
  logic               fifo_full, fifo_empty;
  logic               pop_c;
  logic               push_c;
  logic               tmo_hit;
  logic               busy_ok;
  logic               skip_hit;

  assign req_pair = '{addr: req_addr, data: req_data};
  assign req_ready = !fifo_full || pop_c;
  assign push_c    = req_valid && req_ready;
  assign idle      = fifo_empty && (state_q == IDLE);

  jt51_wrseq_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push_c),
    .pop   (pop_c),
    .din   (req_pair),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // A timeout is the TMO-th busy tick; that edge behaves as if busy were low
  assign tmo_hit  = busy && (tmo_q == TMO_W'(TMO - 1));
  assign busy_ok  = !busy || tmo_hit;
  assign skip_hit = (SKIP_ADDR != 0) && last_vld_q && (head.addr == last_addr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      work_q      <= '0;
      last_addr_q <= '0;
      last_vld_q  <= 1'b0;
      tmo_q       <= '0;
      write       <= 1'b0;
      a0          <= 1'b0;
      dout        <= '0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_nx;
      work_q      <= work_nx;
      last_addr_q <= last_addr_nx;
      last_vld_q  <= last_vld_nx;
      tmo_q       <= tmo_nx;
      write       <= write_nx;
      a0          <= a0_nx;
      dout        <= dout_nx;
      err         <= err_nx;
    end
  end

  always_comb begin
    state_nx     = state_q;
    work_nx      = work_q;
    last_addr_nx = last_addr_q;
    last_vld_nx  = last_vld_q;
    tmo_nx       = tmo_q;
    write_nx     = write;
    a0_nx        = a0;
    dout_nx      = dout;
    err_nx       = err;
    pop_c        = 1'b0;

    if (cen) begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            pop_c    = 1'b1;
            work_nx  = head;
            write_nx = 1'b1;
            if (skip_hit) begin
              state_nx = DATA;
              a0_nx    = 1'b1;
              dout_nx  = head.data;
            end else begin
              state_nx = ADDR;
              a0_nx    = 1'b0;
              dout_nx  = head.addr;
            end
          end
        end
        ADDR: begin
          if (busy_ok) begin
            write_nx     = 1'b0;
            last_addr_nx = work_q.addr;
            // A forced accept may not have reached the chip, so do not trust it
            last_vld_nx  = !tmo_hit;
            state_nx     = WAIT_A;
          end
        end
        WAIT_A: begin
          if (busy_ok) begin
            write_nx = 1'b1;
            a0_nx    = 1'b1;
            dout_nx  = work_q.data;
            state_nx = DATA;
          end
        end
        DATA: begin
          if (busy_ok) begin
            write_nx = 1'b0;
            state_nx = WAIT_D;
          end
        end
        WAIT_D: begin
          if (busy_ok) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end

    if (err_clr) err_nx = 1'b0;
    if (cen && tmo_hit && is_timed(state_q)) err_nx = 1'b1;

    if (flush) begin
      state_nx    = IDLE;
      write_nx    = 1'b0;
      last_vld_nx = 1'b0;
      pop_c       = 1'b0;
    end

    if (state_nx != state_q) begin
      tmo_nx = '0;
    end else if (cen && busy && is_timed(state_q)) begin
      tmo_nx = tmo_q + TMO_W'(1);
    end
  end

endmodule

// File: tb/tb_jt51_wrseq.sv
// Directed self-checking bench for jt51_wrseq with a simple chip busy model.
module tb_jt51_wrseq;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned BOUND = 4000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b0;
  logic        cen_run = 1'b0;
  logic        req_valid = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [7:0]  req_data = '0;
  logic        flush = 1'b0;
  logic        err_clr = 1'b0;
  logic        busy;
  logic        busy_force = 1'b0;
  logic        busy_t = 1'b0;

  logic        req_ready, write, a0, idle, err;
  logic [7:0]  dout;
  logic [AW:0] level;
  logic        req_ready_t, write_t, a0_t, idle_t, err_t;
  logic [7:0]  dout_t;
  logic [AW:0] level_t;

  int          tick = 0;
  int          bcnt = 0;
  int          busy_len = 0;
  logic [8:0]  acc_q[$];
  int          acc_t[$];

  int n_checks = 0;
  int n_errors = 0;

  jt51_wrseq #(.DEPTH(DEPTH), .AW(AW), .SKIP_ADDR(1), .TMO(255)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .flush(flush), .write(write), .a0(a0),
    .dout(dout), .busy(busy), .level(level), .idle(idle), .err(err), .err_clr(err_clr)
  );

  jt51_wrseq #(.DEPTH(DEPTH), .AW(AW), .SKIP_ADDR(1), .TMO(4)) dut_t (
    .clk(clk), .rst_n(rst_n), .cen(cen), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready_t), .flush(flush), .write(write_t), .a0(a0_t),
    .dout(dout_t), .busy(busy_t), .level(level_t), .idle(idle_t), .err(err_t), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // cen toggles every clk while running, i.e. one cen edge every 2 clks
  always @(posedge clk) begin
    #1;
    if (cen_run) cen = ~cen;
    else         cen = 1'b0;
  end

  assign busy = busy_force || (bcnt != 0);

  // Chip model: log every accepted write and hold busy for busy_len cen ticks
  always @(posedge clk) begin
    if (cen) tick <= tick + 1;
    if (cen && write && !busy) begin
      acc_q.push_back({a0, dout});
      acc_t.push_back(tick);
      if (busy_len != 0) bcnt <= busy_len;
    end else if (cen && bcnt != 0) begin
      bcnt <= bcnt - 1;
    end
  end

  task automatic push_pair(input logic [7:0] a, input logic [7:0] d);
    bit ok = 1'b0;
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    for (int i = 0; i < int'(BOUND) && !ok; i++) begin
      if (req_ready) ok = 1'b1;
      @(negedge clk);
    end
    req_valid = 1'b0;
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL push_%02h: got ready=0 expected ready=1 within bound", a);
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < int'(BOUND) && !ok; i++) begin
      @(negedge clk);
      if (idle && !busy && bcnt == 0) ok = 1'b1;
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cen_run = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (write !== 1'b0) begin n_errors++; $display("FAIL reset_write: got %b expected 0", write); end
    n_checks++; if (a0 !== 1'b0) begin n_errors++; $display("FAIL reset_a0: got %b expected 0", a0); end
    n_checks++; if (dout !== 8'h00) begin n_errors++; $display("FAIL reset_dout: got %02h expected 00", dout); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b expected 0", err); end
    n_checks++; if (level !== '0) begin n_errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    n_checks++; if (idle !== 1'b1) begin n_errors++; $display("FAIL reset_idle: got %b expected 1", idle); end
  endtask

  task automatic test_single();
    logic [8:0] exp [2] = '{9'h020, 9'h1C7};
    int t0;
    bit ok;
    busy_len = 0;
    acc_q.delete(); acc_t.delete();
    push_pair(8'h20, 8'hC7);
    t0 = tick;
    wait_idle(ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL single_idle: got busy-wait timeout expected idle"); end
    n_checks++; if (tick - t0 != 5) begin n_errors++; $display("FAIL single_cen_edges: got %0d expected 5", tick - t0); end
    n_checks++; if (acc_q.size() != 2) begin n_errors++; $display("FAIL single_count: got %0d expected 2", acc_q.size()); end
    for (int i = 0; i < 2 && i < acc_q.size(); i++) begin
      n_checks++;
      if (acc_q[i] !== exp[i]) begin n_errors++; $display("FAIL single_acc%0d: got %03h expected %03h", i, acc_q[i], exp[i]); end
    end
  endtask

  task automatic test_busy();
    logic [8:0] exp [4] = '{9'h008, 9'h178, 9'h028, 9'h14A};
    bit ok;
    busy_len = 10;
    acc_q.delete(); acc_t.delete();
    push_pair(8'h08, 8'h78);
    push_pair(8'h28, 8'h4A);
    wait_idle(ok);
    busy_len = 0;
    n_checks++; if (!ok) begin n_errors++; $display("FAIL busy_idle: got busy-wait timeout expected idle"); end
    n_checks++; if (acc_q.size() != 4) begin n_errors++; $display("FAIL busy_count: got %0d expected 4", acc_q.size()); end
    for (int i = 0; i < 4 && i < acc_q.size(); i++) begin
      n_checks++;
      if (acc_q[i] !== exp[i]) begin n_errors++; $display("FAIL busy_acc%0d: got %03h expected %03h", i, acc_q[i], exp[i]); end
    end
    for (int i = 1; i < acc_t.size(); i++) begin
      n_checks++;
      if (acc_t[i] - acc_t[i-1] <= 10) begin
        n_errors++;
        $display("FAIL busy_gap%0d: got %0d cen ticks expected more than 10", i, acc_t[i] - acc_t[i-1]);
      end
    end
  endtask

  task automatic test_skip();
    logic [8:0] exp [8] = '{9'h060, 9'h110, 9'h120, 9'h061, 9'h130, 9'h133, 9'h061, 9'h155};
    bit ok;
    busy_len = 0;
    acc_q.delete(); acc_t.delete();
    push_pair(8'h60, 8'h10);
    push_pair(8'h60, 8'h20);
    push_pair(8'h61, 8'h30);
    wait_idle(ok);
    n_checks++; if (acc_q.size() != 5) begin n_errors++; $display("FAIL skip_count: got %0d expected 5", acc_q.size()); end
    push_pair(8'h61, 8'h33);
    wait_idle(ok);
    do_flush();
    push_pair(8'h61, 8'h55);
    wait_idle(ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL skip_idle: got busy-wait timeout expected idle"); end
    n_checks++; if (acc_q.size() != 8) begin n_errors++; $display("FAIL skip_total: got %0d expected 8", acc_q.size()); end
    for (int i = 0; i < 8 && i < acc_q.size(); i++) begin
      n_checks++;
      if (acc_q[i] !== exp[i]) begin n_errors++; $display("FAIL skip_acc%0d: got %03h expected %03h", i, acc_q[i], exp[i]); end
    end
  endtask

  task automatic test_fill();
    int taken = 0;
    bit rdy;
    bit ok;
    do_flush();
    cen_run = 1'b0;
    busy_force = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < int'(DEPTH) + 2; i++) begin
      req_valid = 1'b1;
      req_addr  = 8'h30 + 8'(i);
      req_data  = 8'hA0 + 8'(i);
      rdy = req_ready;
      @(negedge clk);
      if (rdy) taken++;
    end
    req_valid = 1'b0;
    n_checks++; if (taken != int'(DEPTH)) begin n_errors++; $display("FAIL fill_taken: got %0d expected %0d", taken, DEPTH); end
    n_checks++; if (level !== (AW+1)'(DEPTH)) begin n_errors++; $display("FAIL fill_level: got %0d expected %0d", level, DEPTH); end
    n_checks++; if (req_ready !== 1'b0) begin n_errors++; $display("FAIL fill_ready: got %b expected 0", req_ready); end
    acc_q.delete(); acc_t.delete();
    busy_force = 1'b0;
    cen_run = 1'b1;
    wait_idle(ok);
    n_checks++; if (acc_q.size() != 2 * int'(DEPTH)) begin n_errors++; $display("FAIL fill_count: got %0d expected %0d", acc_q.size(), 2 * DEPTH); end
    for (int i = 0; i < int'(DEPTH) && 2 * i + 1 < acc_q.size(); i++) begin
      logic [8:0] ea;
      logic [8:0] ed;
      ea = {1'b0, 8'h30 + 8'(i)};
      ed = {1'b1, 8'hA0 + 8'(i)};
      n_checks++;
      if (acc_q[2*i] !== ea || acc_q[2*i+1] !== ed) begin
        n_errors++;
        $display("FAIL fill_pair%0d: got %03h/%03h expected %03h/%03h", i, acc_q[2*i], acc_q[2*i+1], ea, ed);
      end
    end
  endtask

  task automatic wait_tick();
    int t0 = tick;
    for (int i = 0; i < 100 && tick == t0; i++) @(negedge clk);
  endtask

  task automatic test_timeout();
    bit ok = 1'b0;
    do_flush();
    busy_t = 1'b1;
    push_pair(8'h11, 8'h22);
    for (int i = 0; i < 100 && !ok; i++) begin
      if (write_t) ok = 1'b1;
      else @(negedge clk);
    end
    n_checks++; if (!ok) begin n_errors++; $display("FAIL tmo_start: got write=0 expected write=1"); end
    repeat (3) wait_tick();
    n_checks++; if (err_t !== 1'b0 || write_t !== 1'b1) begin
      n_errors++; $display("FAIL tmo_early: got err=%b write=%b expected err=0 write=1", err_t, write_t);
    end
    wait_tick();
    n_checks++; if (err_t !== 1'b1) begin n_errors++; $display("FAIL tmo_err: got %b expected 1", err_t); end
    n_checks++; if (write_t !== 1'b0) begin n_errors++; $display("FAIL tmo_advance: got write=%b expected 0", write_t); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_checks++; if (err_t !== 1'b0) begin n_errors++; $display("FAIL tmo_clr: got %b expected 0", err_t); end
    busy_t = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (idle_t && idle && bcnt == 0) ok = 1'b1;
    end
    n_checks++; if (!ok) begin n_errors++; $display("FAIL tmo_drain: got not idle expected idle"); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL main_err: got %b expected 0", err); end
  endtask

  task automatic test_reset_mid();
    logic [8:0] exp [2] = '{9'h044, 9'h166};
    bit ok = 1'b0;
    busy_len = 0;
    push_pair(8'h44, 8'h99);
    for (int i = 0; i < 100 && !ok; i++) begin
      if (write && a0) ok = 1'b1;
      else @(negedge clk);
    end
    busy_force = 1'b1;
    n_checks++; if (!ok) begin n_errors++; $display("FAIL rst_data: got no data phase expected data phase"); end
    push_pair(8'h44, 8'h77);
    n_checks++; if (level !== (AW+1)'(1)) begin n_errors++; $display("FAIL rst_prelevel: got %0d expected 1", level); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (write !== 1'b0) begin n_errors++; $display("FAIL rst_write: got %b expected 0", write); end
    n_checks++; if (level !== '0) begin n_errors++; $display("FAIL rst_level: got %0d expected 0", level); end
    @(negedge clk);
    rst_n = 1'b1;
    busy_force = 1'b0;
    @(negedge clk);
    acc_q.delete(); acc_t.delete();
    push_pair(8'h44, 8'h66);
    wait_idle(ok);
    n_checks++; if (acc_q.size() != 2) begin n_errors++; $display("FAIL rst_count: got %0d expected 2", acc_q.size()); end
    for (int i = 0; i < 2 && i < acc_q.size(); i++) begin
      n_checks++;
      if (acc_q[i] !== exp[i]) begin n_errors++; $display("FAIL rst_acc%0d: got %03h expected %03h", i, acc_q[i], exp[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_busy();
    test_skip();
    test_fill();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
